// File: rtl/sc_match_scheduler.sv
// sc_match_scheduler
//   Collects per-slot note-match triggers, captures |song_time - match_time|
//   at trigger time, and issues queued matches one at a time (round-robin)
//   to the scorer over a valid/ready handshake.
//   Optional feature macro: SC_SCHED_DROP_COUNT_EN (saturating drop counter).
module sc_match_scheduler #(
  parameter int N_SLOTS = 37,
  parameter int TW      = 16,
  parameter int SW      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TW-1:0]         song_time,
  input  logic [N_SLOTS-1:0]    match_trigger,
  input  logic [N_SLOTS*TW-1:0] match_time,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SW-1:0]         out_slot,
  output logic [TW-1:0]         out_dt,
  output logic [N_SLOTS-1:0]    pending,
  output logic [7:0]            drop_count
);

  localparam logic [SW:0]   N_EXT = (SW+1)'(N_SLOTS);
  localparam logic [SW-1:0] LAST  = SW'(N_SLOTS - 1);

  logic [TW-1:0]      dt_store_q [N_SLOTS];
  logic [TW-1:0]      dt_store_d [N_SLOTS];
  logic [TW-1:0]      dt_new     [N_SLOTS];
  logic [N_SLOTS-1:0] pending_q;
  logic [N_SLOTS-1:0] pending_d;
  logic [SW-1:0]      rr_ptr_q;
  logic [SW-1:0]      rr_ptr_d;
  logic               out_valid_q;
  logic [SW-1:0]      out_slot_q;
  logic [TW-1:0]      out_dt_q;

  logic               load;
  logic               grant_found;
  logic [SW-1:0]      grant_idx;
  logic               grant_en;
  logic [N_SLOTS-1:0] grant_oh;

  // Absolute timing error of every slot against the current song time
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      if (song_time >= match_time[i*TW +: TW]) begin
        dt_new[i] = song_time - match_time[i*TW +: TW];
      end else begin
        dt_new[i] = match_time[i*TW +: TW] - song_time;
      end
    end
  end

  // Round-robin search: first pending slot at or above rr_ptr, wrapping to 0
  always_comb begin
    logic [SW:0]   sum;
    logic [SW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      sum = {1'b0, rr_ptr_q} + (SW+1)'(k);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end
      cand = sum[SW-1:0];
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign grant_en = load && grant_found;
  assign rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + SW'(1);

  // One-hot view of this cycle's grant, shared by queue update and drop detection
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      grant_oh[i] = grant_en && (grant_idx == SW'(i));
    end
  end

  // Queue update: a trigger sets (and wins over a same-cycle grant); first capture is kept
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      dt_store_d[i] = dt_store_q[i];
      if (match_trigger[i]) begin
        pending_d[i] = 1'b1;
        if (!pending_q[i] || grant_oh[i]) begin
          dt_store_d[i] = dt_new[i];
        end
      end else if (grant_oh[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Pending flags, round-robin pointer and presented match registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_slot_q  <= '0;
      out_dt_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        out_valid_q <= grant_found;
        if (grant_found) begin
          out_slot_q <= grant_idx;
          out_dt_q   <= dt_store_q[grant_idx];
          rr_ptr_q   <= rr_ptr_d;
        end
      end
    end
  end

  // Captured timing errors, one per slot
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        dt_store_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        dt_store_q[i] <= dt_store_d[i];
      end
    end
  end

`ifdef SC_SCHED_DROP_COUNT_EN
  logic       drop_any;
  logic [7:0] drop_count_q;

  // A drop is a re-trigger on a slot that is still queued and not leaving this cycle
  always_comb begin
    drop_any = |(match_trigger & pending_q & ~grant_oh);
  end

  // Saturating count of cycles containing at least one drop
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
    end else if (drop_any && (drop_count_q != 8'hFF)) begin
      drop_count_q <= drop_count_q + 8'd1;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_slot  = out_slot_q;
  assign out_dt    = out_dt_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_sc_match_scheduler.sv
// Directed self-checking bench for sc_match_scheduler.
module tb_sc_match_scheduler;

  localparam int N  = 37;
  localparam int TW = 16;
  localparam int SW = 6;
`ifdef SC_SCHED_DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [TW-1:0]     song_time;
  logic [N-1:0]      match_trigger;
  logic [N*TW-1:0]   match_time;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_slot;
  logic [TW-1:0]     out_dt;
  logic [N-1:0]      pending;
  logic [7:0]        drop_count;

  int checks = 0;
  int errors = 0;

  sc_match_scheduler #(.N_SLOTS(N), .TW(TW), .SW(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .song_time    (song_time),
    .match_trigger(match_trigger),
    .match_time   (match_time),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_slot     (out_slot),
    .out_dt       (out_dt),
    .pending      (pending),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic set_mt(input int slot, input logic [TW-1:0] v);
    match_time[slot*TW +: TW] = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; match_trigger = '0; match_time = '0; song_time = '0;
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_slot", 64'(out_slot), 64'd0);
    check("rst_dt", 64'(out_dt), 64'd0);

    // Single trigger, slot 5, dt = 1000-990
    reset = 1'b0; out_ready = 1'b1; song_time = 16'd1000; set_mt(5, 16'd990);
    match_trigger = oh(5);
    tick();
    check("t1_pending", 64'(pending), 64'(oh(5)));
    check("t1_valid_lat", 64'(out_valid), 64'd0);
    match_trigger = '0;
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_slot", 64'(out_slot), 64'd5);
    check("t1_dt", 64'(out_dt), 64'd10);
    check("t1_pend_clr", 64'(pending), 64'd0);
    tick();
    check("t1_idle", 64'(out_valid), 64'd0);

    // Three simultaneous triggers from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    set_mt(3, 16'd500); set_mt(10, 16'd520); set_mt(36, 16'd480); song_time = 16'd505;
    match_trigger = oh(3) | oh(10) | oh(36);
    tick();
    match_trigger = '0;
    tick();
    check("t2_a_valid", 64'(out_valid), 64'd1);
    check("t2_a_slot", 64'(out_slot), 64'd3);
    check("t2_a_dt", 64'(out_dt), 64'd5);
    tick();
    check("t2_b_slot", 64'(out_slot), 64'd10);
    check("t2_b_dt", 64'(out_dt), 64'd15);
    tick();
    check("t2_c_slot", 64'(out_slot), 64'd36);
    check("t2_c_dt", 64'(out_dt), 64'd25);
    check("t2_c_valid", 64'(out_valid), 64'd1);
    tick();
    check("t2_idle", 64'(out_valid), 64'd0);

    // Backpressure: slot 7 held while out_ready low, then slot 12
    out_ready = 1'b0; song_time = 16'd100; set_mt(7, 16'd0); set_mt(12, 16'd0);
    match_trigger = oh(7) | oh(12);
    tick();
    check("t3_pending", 64'(pending), 64'(oh(7) | oh(12)));
    match_trigger = '0;
    tick();
    check("t3_valid", 64'(out_valid), 64'd1);
    check("t3_slot", 64'(out_slot), 64'd7);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_slot", 64'(out_slot), 64'd7);
      check("t3_hold_dt", 64'(out_dt), 64'd100);
    end
    out_ready = 1'b1;
    tick();
    check("t3_next_valid", 64'(out_valid), 64'd1);
    check("t3_next_slot", 64'(out_slot), 64'd12);
    tick();
    check("t3_idle", 64'(out_valid), 64'd0);

    // Round-robin fairness: after 36 wrap to 0 then 20; after 10 go 15 then 2
    match_trigger = oh(36);
    tick();
    match_trigger = oh(0) | oh(20);
    tick();
    check("t4_slot36", 64'(out_slot), 64'd36);
    check("t4_pend", 64'(pending), 64'(oh(0) | oh(20)));
    match_trigger = '0;
    tick();
    check("t4_slot0", 64'(out_slot), 64'd0);
    tick();
    check("t4_slot20", 64'(out_slot), 64'd20);
    match_trigger = oh(10);
    tick();
    match_trigger = oh(2) | oh(15);
    tick();
    check("t4_slot10", 64'(out_slot), 64'd10);
    match_trigger = '0;
    tick();
    check("t4_slot15", 64'(out_slot), 64'd15);
    tick();
    check("t4_slot2", 64'(out_slot), 64'd2);
    check("t4_valid2", 64'(out_valid), 64'd1);
    tick();
    check("t4_idle", 64'(out_valid), 64'd0);

    // Re-trigger slot 4 while stalled: first capture (dt=0) wins
    out_ready = 1'b0;
    match_trigger = oh(30);
    tick();
    match_trigger = oh(4); song_time = 16'd1000; set_mt(4, 16'd1000);
    tick();
    check("t5_blocker", 64'(out_slot), 64'd30);
    check("t5_pend4", 64'(pending), 64'(oh(4)));
    song_time = 16'd1050;
    tick();
    check("t5_drop1", 64'(drop_count), DC_EN ? 64'd1 : 64'd0);
    check("t5_pend_kept", 64'(pending), 64'(oh(4)));
    check("t5_held", 64'(out_slot), 64'd30);
    match_trigger = '0; out_ready = 1'b1;
    tick();
    check("t5_slot4", 64'(out_slot), 64'd4);
    check("t5_dt_first", 64'(out_dt), 64'd0);
    tick();
    check("t5_idle", 64'(out_valid), 64'd0);

    // Many drops: counter saturates at 255
    out_ready = 1'b0;
    match_trigger = oh(30);
    tick();
    match_trigger = oh(4);
    tick();
    repeat (10) tick();
    check("t5_drop11", 64'(drop_count), DC_EN ? 64'd11 : 64'd0);
    repeat (290) tick();
    match_trigger = '0;
    check("t5_drop_sat", 64'(drop_count), DC_EN ? 64'd255 : 64'd0);

    // Reset mid-operation discards queue and presented match
    out_ready = 1'b1;
    tick(); tick();
    check("t6_drain", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    match_trigger = oh(9);
    tick();
    match_trigger = oh(1) | oh(2);
    tick();
    check("t6_pre_slot", 64'(out_slot), 64'd9);
    check("t6_pre_pend", 64'(pending), 64'(oh(1) | oh(2)));
    match_trigger = oh(5); reset = 1'b1;
    tick();
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_pend", 64'(pending), 64'd0);
    check("t6_rst_drop", 64'(drop_count), 64'd0);
    reset = 1'b0; match_trigger = '0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_quiet_valid", 64'(out_valid), 64'd0);
      check("t6_quiet_pend", 64'(pending), 64'd0);
    end
    song_time = 16'd50; set_mt(0, 16'd20);
    match_trigger = oh(0);
    tick();
    match_trigger = '0;
    tick();
    check("t6_new_valid", 64'(out_valid), 64'd1);
    check("t6_new_slot", 64'(out_slot), 64'd0);
    check("t6_new_dt", 64'(out_dt), 64'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
